// File: rtl/alu_shift_rotate_unit.sv
// rtl/alu_shift_rotate_unit.sv - ALU B register, L flag and serial shift/rotate engine
module alu_shift_rotate_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ibus,
    input  logic             write_b,
    input  logic             start,
    input  logic             op_rotate,
    input  logic             op_arithmetic,
    input  logic             op_right,
    input  logic [3:0]       op_dist,
    input  logic             l_in,
    output logic [WIDTH-1:0] b,
    output logic             fl,
    output logic             busy,
    output logic             shift_strobe
);

    logic [3:0]       count;
    logic             rot_q;
    logic             ari_q;
    logic             right_q;
    logic [WIDTH-1:0] step_b;
    logic             step_fl;

    // One-place step; the bit shifted out always lands in L.
    always_comb begin
        step_b  = b;
        step_fl = fl;
        if (right_q) begin
            step_fl = b[0];
            if (rot_q)
                step_b = {(ari_q ? b[0] : fl), b[WIDTH-1:1]};
            else
                step_b = {(ari_q ? b[WIDTH-1] : 1'b0), b[WIDTH-1:1]};
        end else begin
            step_fl = b[WIDTH-1];
            if (rot_q)
                step_b = {b[WIDTH-2:0], (ari_q ? b[WIDTH-1] : fl)};
            else
                step_b = {b[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b       <= '0;
            fl      <= 1'b0;
            count   <= 4'd0;
            rot_q   <= 1'b0;
            ari_q   <= 1'b0;
            right_q <= 1'b0;
        end else if (count != 4'd0) begin
            b     <= step_b;
            fl    <= step_fl;
            count <= count - 4'd1;
        end else begin
            if (write_b)
                b <= ibus;
            if (start) begin
                rot_q   <= op_rotate;
                ari_q   <= op_arithmetic;
                right_q <= op_right;
                count   <= op_dist;
                fl      <= l_in;
            end
        end
    end

    assign busy         = (count != 4'd0);
    assign shift_strobe = busy;

endmodule

// File: tb/tb_alu_shift_rotate_unit.sv
// tb/tb_alu_shift_rotate_unit.sv - randomized self-checking bench for alu_shift_rotate_unit
module tb_alu_shift_rotate_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ibus;
    logic        write_b;
    logic        start;
    logic        op_rotate;
    logic        op_arithmetic;
    logic        op_right;
    logic [3:0]  op_dist;
    logic        l_in;
    logic [15:0] b;
    logic        fl;
    logic        busy;
    logic        shift_strobe;

    int tests = 0;
    int fails = 0;

    alu_shift_rotate_unit #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .ibus(ibus), .write_b(write_b), .start(start),
        .op_rotate(op_rotate), .op_arithmetic(op_arithmetic), .op_right(op_right),
        .op_dist(op_dist), .l_in(l_in), .b(b), .fl(fl), .busy(busy),
        .shift_strobe(shift_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-operation reference: shifts as plain arithmetic, rotates as
    // rotations of a 16- or 17-bit quantity.
    task automatic model(input logic [2:0] op, input int d, input logic [15:0] v,
                         input logic l0, output logic [15:0] rb, output logic rl);
        int unsigned x, r;
        rb = v;
        rl = l0;
        if (d == 0) return;
        x = v;
        case (op)
            3'b000, 3'b010: begin r = x << d; rb = r[15:0]; rl = r[16]; end
            3'b001: begin rb = 16'(x >> d); r = x >> (d - 1); rl = r[0]; end
            3'b011: begin
                rb = 16'($signed(v) >>> d);
                r = x >> (d - 1); rl = r[0];
            end
            3'b100: begin
                x = {15'd0, l0, v};
                r = ((x << d) | (x >> (17 - d))) & 32'h1FFFF;
                rb = r[15:0]; rl = r[16];
            end
            3'b101: begin
                x = {15'd0, l0, v};
                r = ((x >> d) | (x << (17 - d))) & 32'h1FFFF;
                rb = r[15:0]; rl = r[16];
            end
            3'b110: begin
                r = ((x << d) | (x >> (16 - d))) & 32'hFFFF;
                rb = r[15:0]; rl = r[0];
            end
            default: begin
                r = ((x >> d) | (x << (16 - d))) & 32'hFFFF;
                rb = r[15:0]; rl = r[15];
            end
        endcase
    endtask

    // Load and start together, pester the unit while busy, then check result.
    task automatic run_op(input logic [2:0] op, input int d, input logic [15:0] v,
                          input logic l0);
        logic [15:0] eb;
        logic        el;
        int          n, guard;
        model(op, d, v, l0, eb, el);
        @(negedge clk);
        ibus = v; write_b = 1'b1; start = 1'b1;
        {op_rotate, op_arithmetic, op_right} = op;
        op_dist = 4'(d); l_in = l0;
        @(negedge clk);
        write_b = 1'b0; start = 1'b0;
        n = 0; guard = 0;
        while (busy && guard < 40) begin
            if (shift_strobe) n++;
            if (n == 1) begin
                write_b = 1'b1; start = 1'b1; ibus = 16'($urandom);
                op_right = ~op_right; op_rotate = ~op_rotate;
                op_dist = 4'($urandom); l_in = ~l_in;
            end
            @(negedge clk);
            write_b = 1'b0; start = 1'b0;
            guard++;
        end
        check($sformatf("strobes op%0d d%0d", op, d), n, d);
        check($sformatf("b op%0d d%0d v%0h", op, d, v), {16'd0, b}, {16'd0, eb});
        check($sformatf("fl op%0d d%0d v%0h", op, d, v), {31'd0, fl}, {31'd0, el});
        check("strobe idle", {31'd0, shift_strobe}, 32'd0);
    endtask

    initial begin
        logic [15:0] v;
        reset = 1'b1; ibus = 16'hFFFF; write_b = 1'b1; start = 1'b1;
        op_rotate = 1'b0; op_arithmetic = 1'b0; op_right = 1'b0;
        op_dist = 4'd5; l_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset busy", {31'd0, busy}, 32'd0);
            check("reset b", {16'd0, b}, 32'd0);
            check("reset fl", {31'd0, fl}, 32'd0);
            check("reset strobe", {31'd0, shift_strobe}, 32'd0);
        end
        reset = 1'b0; write_b = 1'b0; start = 1'b0;

        run_op(3'b100, 4, 16'h1234, 1'b0);
        run_op(3'b100, 1, 16'h8000, 1'b1);
        run_op(3'b011, 15, 16'h8000, 1'b0);
        run_op(3'b001, 0, 16'hABCD, 1'b0);
        run_op(3'b001, 0, 16'hABCD, 1'b1);

        // Reset in the middle of an operation aborts it on the next edge.
        @(negedge clk);
        ibus = 16'h5A5A; write_b = 1'b1; start = 1'b1;
        {op_rotate, op_arithmetic, op_right} = 3'b101; op_dist = 4'd10; l_in = 1'b1;
        @(negedge clk);
        write_b = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("midop busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort b", {16'd0, b}, 32'd0);
        check("abort fl", {31'd0, fl}, 32'd0);

        v = 16'h1234;
        for (int op = 0; op < 8; op++) begin
            for (int d = 0; d < 16; d++) begin
                run_op(3'(op), d, v, 1'($urandom));
                v = v + 16'd21;
            end
        end
        for (int k = 0; k < 40; k++)
            run_op(3'($urandom), int'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
